// File: rtl/qix_video_scanout.sv
// Raster timing and pixel fetch for the 256x256 video: VRAM read, then palette lookup, then pixel mux byte with matched sync/blank.
// Optional cocktail flip is enabled by defining QIX_FLIP_EN (adds the i_Flip input).
module qix_video_scanout #(
  parameter int H_TOTAL      = 320,
  parameter int H_ACTIVE     = 256,
  parameter int H_SYNC_START = 272,
  parameter int H_SYNC_LEN   = 24,
  parameter int V_TOTAL      = 264,
  parameter int V_ACTIVE     = 256,
  parameter int V_SYNC_START = 258,
  parameter int V_SYNC_LEN   = 3
) (
  input  logic        clk_vid,
  input  logic        i_Reset,
  input  logic        i_CE_Pix,
  input  logic [1:0]  i_PalBank,
`ifdef QIX_FLIP_EN
  input  logic        i_Flip,
`endif
  output logic [15:0] o_VRAM_Addr,
  input  logic [7:0]  i_VRAM_Data,
  output logic [9:0]  o_Pal_Addr,
  input  logic [7:0]  i_Pal_Data,
  output logic [7:0]  o_Pixel,
  output logic        o_HSync,
  output logic        o_VSync,
  output logic        o_HBlank,
  output logic        o_VBlank,
  output logic        o_VBlank_Start
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS     = HW'(H_SYNC_START);
  localparam logic [HW-1:0] H_SE     = HW'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_M1 = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_SS     = VW'(V_SYNC_START);
  localparam logic [VW-1:0] V_SE     = VW'(V_SYNC_START + V_SYNC_LEN);

  logic [HW-1:0] hcnt_reg, hcnt_next;
  logic [VW-1:0] vcnt_reg, vcnt_next;
  logic [1:0]    bank_reg;
  logic          h_wrap;
  logic          line_start;
  logic          flip_eff;
  logic          vblank_start_next;
  logic [15:0]   raw_addr;
  logic [15:0]   addr_next;
  // Flag bundle order: {active, hsync, vsync, hblank, vblank}
  logic [4:0]    flags_next;
  logic [4:0]    flags_s0_reg;
  logic [4:0]    flags_s1_reg;

`ifdef QIX_FLIP_EN
  logic          flip_reg;
`endif

  always_comb begin
    h_wrap     = (hcnt_reg == H_LAST);
    line_start = (hcnt_reg == '0);
    hcnt_next  = h_wrap ? '0 : hcnt_reg + HW'(1);
    vcnt_next  = vcnt_reg;
    if (h_wrap) begin
      vcnt_next = (vcnt_reg == V_LAST) ? '0 : vcnt_reg + VW'(1);
    end

    vblank_start_next = i_CE_Pix && h_wrap && (vcnt_reg == V_ACT_M1);

`ifdef QIX_FLIP_EN
    // The flip latch updates on the same tick it is first needed, so bypass it at line start.
    flip_eff = line_start ? i_Flip : flip_reg;
`else
    flip_eff = 1'b0;
`endif

    raw_addr  = {vcnt_reg[7:0], hcnt_reg[7:0]};
    addr_next = flip_eff ? ~raw_addr : raw_addr;

    flags_next[4] = (hcnt_reg < H_ACT) && (vcnt_reg < V_ACT);
    flags_next[3] = (hcnt_reg >= H_SS) && (hcnt_reg < H_SE);
    flags_next[2] = (vcnt_reg >= V_SS) && (vcnt_reg < V_SE);
    flags_next[1] = !(hcnt_reg < H_ACT);
    flags_next[0] = !(vcnt_reg < V_ACT);
  end

  always_ff @(posedge clk_vid) begin
    if (i_Reset) begin
      hcnt_reg       <= '0;
      vcnt_reg       <= '0;
      bank_reg       <= '0;
`ifdef QIX_FLIP_EN
      flip_reg       <= 1'b0;
`endif
      o_VRAM_Addr    <= '0;
      o_Pal_Addr     <= '0;
      o_Pixel        <= '0;
      flags_s0_reg   <= '0;
      flags_s1_reg   <= '0;
      o_HSync        <= 1'b0;
      o_VSync        <= 1'b0;
      o_HBlank       <= 1'b0;
      o_VBlank       <= 1'b0;
      o_VBlank_Start <= 1'b0;
    end else begin
      o_VBlank_Start <= vblank_start_next;
      if (i_CE_Pix) begin
        hcnt_reg <= hcnt_next;
        vcnt_reg <= vcnt_next;
        // Bank (and flip) changes take effect from the next line start.
        if (line_start) begin
          bank_reg <= i_PalBank;
`ifdef QIX_FLIP_EN
          flip_reg <= i_Flip;
`endif
        end
        o_VRAM_Addr  <= addr_next;
        flags_s0_reg <= flags_next;

        o_Pal_Addr   <= {bank_reg, i_VRAM_Data};
        flags_s1_reg <= flags_s0_reg;

        o_Pixel  <= flags_s1_reg[4] ? i_Pal_Data : 8'h00;
        o_HSync  <= flags_s1_reg[3];
        o_VSync  <= flags_s1_reg[2];
        o_HBlank <= flags_s1_reg[1];
        o_VBlank <= flags_s1_reg[0];
      end
    end
  end

endmodule

// File: tb/tb_qix_video_scanout.sv
// Self-checking bench for qix_video_scanout: a per-tick scoreboard plus a table of spot checks and reset/CE corner sequences.
`timescale 1ns/1ps
module tb_qix_video_scanout;

  localparam int H_TOTAL = 320;
  localparam int V_TOTAL = 264;
`ifdef QIX_FLIP_EN
  localparam bit FLIP_BUILD = 1'b1;
`else
  localparam bit FLIP_BUILD = 1'b0;
`endif

  localparam int SEL_ADDR = 0, SEL_PIX = 1, SEL_HS = 2, SEL_BANK = 3,
                 SEL_VBS = 4, SEL_HB = 5, SEL_VB = 6, SEL_PALA = 7;

  logic clk_vid = 1'b0;
  always #5 clk_vid = ~clk_vid;

  logic        i_Reset = 1'b1;
  logic        i_CE_Pix = 1'b1;
  logic [1:0]  i_PalBank = 2'd0;
  logic        flip_drv = 1'b0;
  logic [15:0] o_VRAM_Addr;
  logic [7:0]  i_VRAM_Data;
  logic [9:0]  o_Pal_Addr;
  logic [7:0]  i_Pal_Data;
  logic [7:0]  o_Pixel;
  logic        o_HSync, o_VSync, o_HBlank, o_VBlank, o_VBlank_Start;

  logic [7:0] vram [0:65535];
  logic [7:0] pal  [0:1023];

  // Both RAMs present data by the tick after the registered address.
  assign i_VRAM_Data = vram[o_VRAM_Addr];
  assign i_Pal_Data  = pal[o_Pal_Addr];

  qix_video_scanout dut (
    .clk_vid        (clk_vid),
    .i_Reset        (i_Reset),
    .i_CE_Pix       (i_CE_Pix),
    .i_PalBank      (i_PalBank),
`ifdef QIX_FLIP_EN
    .i_Flip         (flip_drv),
`endif
    .o_VRAM_Addr    (o_VRAM_Addr),
    .i_VRAM_Data    (i_VRAM_Data),
    .o_Pal_Addr     (o_Pal_Addr),
    .i_Pal_Data     (i_Pal_Data),
    .o_Pixel        (o_Pixel),
    .o_HSync        (o_HSync),
    .o_VSync        (o_VSync),
    .o_HBlank       (o_HBlank),
    .o_VBlank       (o_VBlank),
    .o_VBlank_Start (o_VBlank_Start)
  );

  typedef struct {
    logic [15:0] addr;
    logic [9:0]  paladdr;
    logic [7:0]  pixel;
    logic        hs, vs, hb, vb;
  } exp_t;

  typedef struct {
    int          tick;
    int          sel;
    logic [15:0] exp;
  } vec_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int tick = 0;
  int mh = 0, mv = 0;
  logic [1:0] mbank = 2'd0;
  logic mflip = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s tick=%0d got=%0h want=%0h", name, tick, act, exp);
    end
  endtask

  function automatic logic [15:0] field(input int sel);
    case (sel)
      SEL_ADDR: field = o_VRAM_Addr;
      SEL_PIX:  field = {8'h00, o_Pixel};
      SEL_HS:   field = {15'd0, o_HSync};
      SEL_BANK: field = {14'd0, o_Pal_Addr[9:8]};
      SEL_VBS:  field = {15'd0, o_VBlank_Start};
      SEL_HB:   field = {15'd0, o_HBlank};
      SEL_VB:   field = {15'd0, o_VBlank};
      default:  field = {6'd0, o_Pal_Addr};
    endcase
  endfunction

  // Scoreboard: one expected record per CE tick; the front of a full queue is the pixel now at the output.
  initial begin : monitor
    logic s_rst, s_ce, s_flip, eflip, exp_vbs, armed, active;
    logic [1:0] s_bank;
    exp_t e, f;
    armed = 1'b0;
    forever begin
      @(posedge clk_vid);
      s_rst  = i_Reset;
      s_ce   = i_CE_Pix;
      s_bank = i_PalBank;
      s_flip = FLIP_BUILD ? flip_drv : 1'b0;
      exp_vbs = !s_rst && s_ce && mh == H_TOTAL - 1 && mv == 255;
      if (s_rst) begin
        armed = 1'b1;
        sb.delete();
        mh = 0; mv = 0; mbank = 2'd0; mflip = 1'b0; tick = 0;
      end else if (s_ce) begin
        eflip = (mh == 0) ? s_flip : mflip;
        if (mh == 0) begin
          mbank = s_bank;
          mflip = s_flip;
        end
        e.addr    = {8'(mv), 8'(mh)};
        if (eflip) e.addr = ~e.addr;
        e.paladdr = {mbank, vram[e.addr]};
        active    = (mh < 256) && (mv < 256);
        e.pixel   = active ? pal[e.paladdr] : 8'h00;
        e.hs      = (mh >= 272) && (mh < 296);
        e.vs      = (mv >= 258) && (mv < 261);
        e.hb      = !(mh < 256);
        e.vb      = !(mv < 256);
        sb.push_back(e);
        if (sb.size() > 3) void'(sb.pop_front());
        tick++;
        mh++;
        if (mh == H_TOTAL) begin
          mh = 0;
          mv++;
          if (mv == V_TOTAL) mv = 0;
        end
      end
      #1;
      if (armed) begin
        check("sb_addr", o_VRAM_Addr, (sb.size() >= 1) ? sb[sb.size()-1].addr : 16'h0);
        check("sb_paladdr", o_Pal_Addr, (sb.size() >= 2) ? sb[sb.size()-2].paladdr : 10'h0);
        if (sb.size() == 3) f = sb[0];
        else f = '{addr: 16'h0, paladdr: 10'h0, pixel: 8'h0, hs: 1'b0, vs: 1'b0, hb: 1'b0, vb: 1'b0};
        check("sb_pixel", o_Pixel, f.pixel);
        check("sb_hsync", o_HSync, f.hs);
        check("sb_vsync", o_VSync, f.vs);
        check("sb_hblank", o_HBlank, f.hb);
        check("sb_vblank", o_VBlank, f.vb);
        check("sb_vblank_start", o_VBlank_Start, exp_vbs);
      end
    end
  end

  initial begin : watchdog
    repeat (99000) @(posedge clk_vid);
    $display("FAIL watchdog tick=%0d got=running want=finished", tick);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog expired");
  end

  int cyc = 0;

  // CE high on one clock in four, until the model tick counter reaches target.
  task automatic ce_run(input int target);
    int g;
    g = 0;
    while (tick < target && g < 20000) begin
      @(negedge clk_vid);
      i_CE_Pix = (cyc % 4 == 0);
      cyc++;
      g++;
    end
    @(negedge clk_vid);
    i_CE_Pix = 1'b0;
    cyc = 1;
    if (tick < target) check("ce_run_timeout", tick, target);
  endtask

  vec_t tbl[18];

  initial begin : stim
    int ti, g;
    logic [15:0] a0;
    for (int i = 0; i < 65536; i++) vram[i] = 8'(i * 7 + (i >> 8) * 13);
    for (int i = 0; i < 1024; i++) pal[i] = 8'(i * 37 + 11);
    vram[16'h1234] = 8'h5A;
    pal[10'h25A]   = 8'hC3;

    tbl[0]  = '{1,     SEL_ADDR, 16'h0000};
    tbl[1]  = '{3,     SEL_PIX,  {8'h00, pal[{2'd0, vram[0]}]}};
    tbl[2]  = '{6,     SEL_ADDR, 16'h0005};
    tbl[3]  = '{258,   SEL_HB,   16'd0};
    tbl[4]  = '{259,   SEL_HB,   16'd1};
    tbl[5]  = '{274,   SEL_HS,   16'd0};
    tbl[6]  = '{275,   SEL_HS,   16'd1};
    tbl[7]  = '{298,   SEL_HS,   16'd1};
    tbl[8]  = '{299,   SEL_HS,   16'd0};
    tbl[9]  = '{472,   SEL_BANK, 16'd1};
    tbl[10] = '{652,   SEL_BANK, 16'd3};
    tbl[11] = '{5813,  SEL_ADDR, 16'h1234};
    tbl[12] = '{5814,  SEL_PALA, 16'h025A};
    tbl[13] = '{5815,  SEL_PIX,  16'h00C3};
    tbl[14] = '{81920, SEL_VBS,  16'd1};
    tbl[15] = '{81921, SEL_VBS,  16'd0};
    tbl[16] = '{81922, SEL_VB,   16'd0};
    tbl[17] = '{81923, SEL_VB,   16'd1};

    // Main run: CE every clock from reset through the first vertical blank.
    @(negedge clk_vid);
    @(negedge clk_vid);
    i_Reset = 1'b0;
    check("reset_addr", o_VRAM_Addr, 16'h0);
    check("reset_pixel", o_Pixel, 8'h0);
    ti = 0;
    g = 0;
    while (ti < 18 && g < 90000) begin
      @(negedge clk_vid);
      g++;
      if (tick == 50)   i_PalBank = 2'd1;
      if (tick == 420)  i_PalBank = 2'd3;
      if (tick == 1610) i_PalBank = 2'd2;
      while (ti < 18 && tbl[ti].tick == tick) begin
        $display("vec %0d tick=%0d sel=%0d got=%0h", ti, tick, tbl[ti].sel, field(tbl[ti].sel));
        check($sformatf("vec%0d", ti), field(tbl[ti].sel), tbl[ti].exp);
        ti++;
      end
    end
    if (ti < 18) check("table_timeout", ti, 18);

    // CE one clock in four, reset pulsed mid-frame at (v=2, h=200).
    i_PalBank = 2'd0;
    i_Reset = 1'b1;
    @(negedge clk_vid);
    i_Reset = 1'b0;
    cyc = 0;
    ce_run(2 * H_TOTAL + 200);
    $display("seq reset_mid_frame at v=%0d h=%0d", mv, mh);
    i_Reset   = 1'b1;
    i_CE_Pix  = 1'b1;
    i_PalBank = 2'd1;
    flip_drv  = 1'b1;
    @(negedge clk_vid);
    i_Reset  = 1'b0;
    i_CE_Pix = 1'b0;
    check("rst_mid_addr", o_VRAM_Addr, 16'h0);
    check("rst_mid_paladdr", o_Pal_Addr, 10'h0);
    check("rst_mid_pixel", o_Pixel, 8'h0);
    check("rst_mid_hblank", o_HBlank, 1'b0);
    check("rst_mid_vblank_start", o_VBlank_Start, 1'b0);

    cyc = 1;
    ce_run(1);
    a0 = FLIP_BUILD ? 16'hFFFF : 16'h0000;
    $display("seq restart tick=%0d addr=%0h pixel=%0h", tick, o_VRAM_Addr, o_Pixel);
    check("restart_addr", o_VRAM_Addr, a0);
    check("restart_no_stale", o_Pixel, 8'h0);
    ce_run(3);
    $display("seq first_pixel tick=%0d pixel=%0h", tick, o_Pixel);
    check("restart_pixel", o_Pixel, pal[{2'd1, vram[a0]}]);

    // Flip dropped mid-line: the rest of line 0 stays flipped, line 1 is not.
    ce_run(100);
    flip_drv = 1'b0;
    ce_run(H_TOTAL + 10);
    $display("seq flip_next_line tick=%0d addr=%0h", tick, o_VRAM_Addr);
    check("flip_next_line_addr", o_VRAM_Addr, {8'd1, 8'd9});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
